// File: rtl/ibex_efpga_pkg.sv
// rtl/ibex_efpga_pkg.sv - shared types and constants for the eFPGA responder
//
// Contents:
//   efpga_state_e         - responder FSM states (IDLE, LAUNCH, WAIT, DONE)
//   EFPGA_TIMEOUT_RESULT  - result word returned when the fabric never answers
//   EFPGA_TIMEOUT_DEFAULT - default handshake-mode wait limit in cycles
package ibex_efpga_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } efpga_state_e;

    localparam logic [31:0] EFPGA_TIMEOUT_RESULT  = 32'hDEADBEEF;
    localparam int unsigned EFPGA_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/ibex_efpga_responder_if.sv
// rtl/ibex_efpga_responder_if.sv - fabric-side bus between responder and eFPGA
//
// Signals:
//   fabric_op_a_o, fabric_op_b_o (32) - operands held to the fabric
//   fabric_operator_o (2)             - operator held to the fabric
//   fabric_start_o                    - one-cycle launch pulse
//   fabric_result_a/b/c_i (32)        - fabric results
//   fabric_valid_i                    - fabric result-valid handshake
// Modports: master (responder side), slave (fabric side).
interface ibex_efpga_responder_if;

    logic [31:0] fabric_op_a_o;
    logic [31:0] fabric_op_b_o;
    logic [1:0]  fabric_operator_o;
    logic        fabric_start_o;
    logic [31:0] fabric_result_a_i;
    logic [31:0] fabric_result_b_i;
    logic [31:0] fabric_result_c_i;
    logic        fabric_valid_i;

    modport master (
        output fabric_op_a_o,
        output fabric_op_b_o,
        output fabric_operator_o,
        output fabric_start_o,
        input  fabric_result_a_i,
        input  fabric_result_b_i,
        input  fabric_result_c_i,
        input  fabric_valid_i
    );

    modport slave (
        input  fabric_op_a_o,
        input  fabric_op_b_o,
        input  fabric_operator_o,
        input  fabric_start_o,
        output fabric_result_a_i,
        output fabric_result_b_i,
        output fabric_result_c_i,
        output fabric_valid_i
    );

endinterface

// File: rtl/ibex_efpga_responder.sv
// rtl/ibex_efpga_responder.sv - core-to-eFPGA request responder with fixed/handshake latency
//
// Launches a fabric operation on a core strobe and returns the fabric results.
// cfg_delay_i != 0 samples results a fixed number of cycles after launch;
// cfg_delay_i == 0 waits for fabric_valid_i.
//
// Optional feature macro: IBEX_EFPGA_TIMEOUT_EN
//   defined   - handshake wait is bounded by TIMEOUT_CYCLES; on expiry results
//               become 32'hDEADBEEF and error_o is set until reset.
//   undefined - handshake wait is unbounded and error_o is tied low.
//
// Ports:
//   clk, rst_n                     - clock, asynchronous active-low reset
//   write_strobe_i                 - core request strobe
//   operator_i (2), operand_a/b_i  - request operator and operands
//   cfg_delay_i (4)                - fixed latency, 0 selects handshake mode
//   fabric                         - fabric bus (ibex_efpga_responder_if.master)
//   result_a/b/c_o (32)            - latched results to core
//   delay_o (4)                    - cfg_delay_i captured with the request
//   done_o, busy_o, error_o        - completion pulse, busy, sticky timeout
module ibex_efpga_responder
    import ibex_efpga_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = EFPGA_TIMEOUT_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          write_strobe_i,
    input  logic [1:0]                    operator_i,
    input  logic [31:0]                   operand_a_i,
    input  logic [31:0]                   operand_b_i,
    input  logic [3:0]                    cfg_delay_i,
    ibex_efpga_responder_if.master        fabric,
    output logic [31:0]                   result_a_o,
    output logic [31:0]                   result_b_o,
    output logic [31:0]                   result_c_o,
    output logic [3:0]                    delay_o,
    output logic                          done_o,
    output logic                          busy_o,
    output logic                          error_o
);

    efpga_state_e state_q, state_d;

    logic [31:0] op_a_q, op_b_q;
    logic [1:0]  operator_q;
    logic [3:0]  delay_q;
    logic [3:0]  cnt_q;
    logic [31:0] res_a_q, res_b_q, res_c_q;

    logic accept;
    logic fixed_mode;
    logic sample;
    logic timeout_hit;

    // Requests are only taken when no operation is in flight.
    assign accept     = write_strobe_i && ((state_q == IDLE) || (state_q == DONE));
    assign fixed_mode = (delay_q != 4'd0);

    // In fixed mode the counter is loaded with D in LAUNCH, so it holds 1 in
    // the D-th WAIT cycle: the cycle whose decrement brings it to zero.
    always_comb begin
        sample = 1'b0;
        if (state_q == WAIT) begin
            if (fixed_mode) begin
                sample = (cnt_q == 4'd1);
            end else begin
                sample = fabric.fabric_valid_i;
            end
        end
    end

`ifdef IBEX_EFPGA_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tcnt_q;
    logic       error_q;

    // tcnt_q holds the number of handshake WAIT cycles already elapsed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q <= 8'd0;
        end else if (state_q == LAUNCH) begin
            tcnt_q <= 8'd0;
        end else if (state_q == WAIT && !fixed_mode) begin
            tcnt_q <= tcnt_q + 8'd1;
        end
    end

    assign timeout_hit = (state_q == WAIT) && !fixed_mode &&
                         !fabric.fabric_valid_i && (tcnt_q == TIMEOUT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_q <= 1'b0;
        end else if (timeout_hit) begin
            error_q <= 1'b1;
        end
    end

    assign error_o = error_q;
`else
    assign timeout_hit = 1'b0;
    assign error_o     = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = LAUNCH;
            LAUNCH:  state_d = WAIT;
            WAIT:    if (sample || timeout_hit) state_d = DONE;
            DONE:    state_d = accept ? LAUNCH : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        fabric.fabric_start_o = 1'b0;
        done_o                = 1'b0;
        busy_o                = 1'b1;
        case (state_q)
            IDLE:    busy_o = 1'b0;
            LAUNCH:  fabric.fabric_start_o = 1'b1;
            DONE:    done_o = 1'b1;
            default: ;
        endcase
    end

    // Request capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_q     <= 32'd0;
            op_b_q     <= 32'd0;
            operator_q <= 2'd0;
            delay_q    <= 4'd0;
        end else if (accept) begin
            op_a_q     <= operand_a_i;
            op_b_q     <= operand_b_i;
            operator_q <= operator_i;
            delay_q    <= cfg_delay_i;
        end
    end

    // Fixed-latency counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else if (state_q == LAUNCH) begin
            cnt_q <= delay_q;
        end else if (state_q == WAIT && fixed_mode) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    // Result latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_a_q <= 32'd0;
            res_b_q <= 32'd0;
            res_c_q <= 32'd0;
        end else if (sample) begin
            res_a_q <= fabric.fabric_result_a_i;
            res_b_q <= fabric.fabric_result_b_i;
            res_c_q <= fabric.fabric_result_c_i;
        end else if (timeout_hit) begin
            res_a_q <= EFPGA_TIMEOUT_RESULT;
            res_b_q <= EFPGA_TIMEOUT_RESULT;
            res_c_q <= EFPGA_TIMEOUT_RESULT;
        end
    end

    assign fabric.fabric_op_a_o     = op_a_q;
    assign fabric.fabric_op_b_o     = op_b_q;
    assign fabric.fabric_operator_o = operator_q;

    assign result_a_o = res_a_q;
    assign result_b_o = res_b_q;
    assign result_c_o = res_c_q;
    assign delay_o    = delay_q;

endmodule

// File: tb/tb_ibex_efpga_responder.sv
// tb/tb_ibex_efpga_responder.sv - directed self-checking bench for ibex_efpga_responder
module tb_ibex_efpga_responder;

    logic        clk;
    logic        rst_n;
    logic        write_strobe_i;
    logic [1:0]  operator_i;
    logic [31:0] operand_a_i;
    logic [31:0] operand_b_i;
    logic [3:0]  cfg_delay_i;
    logic [31:0] result_a_o, result_b_o, result_c_o;
    logic [3:0]  delay_o;
    logic        done_o, busy_o, error_o;

    int checks = 0;
    int errors = 0;

    ibex_efpga_responder_if fab_if ();

    ibex_efpga_responder #(.TIMEOUT_CYCLES(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .write_strobe_i (write_strobe_i),
        .operator_i     (operator_i),
        .operand_a_i    (operand_a_i),
        .operand_b_i    (operand_b_i),
        .cfg_delay_i    (cfg_delay_i),
        .fabric         (fab_if.master),
        .result_a_o     (result_a_o),
        .result_b_o     (result_b_o),
        .result_c_o     (result_c_o),
        .delay_o        (delay_o),
        .done_o         (done_o),
        .busy_o         (busy_o),
        .error_o        (error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_fabric(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        fab_if.fabric_result_a_i = a;
        fab_if.fabric_result_b_i = b;
        fab_if.fabric_result_c_i = c;
    endtask

    task automatic set_req(input logic [3:0] d, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] op);
        cfg_delay_i = d;
        operand_a_i = a;
        operand_b_i = b;
        operator_i  = op;
    endtask

    initial begin
        rst_n          = 1'b0;
        write_strobe_i = 1'b0;
        set_req(4'd0, 32'd0, 32'd0, 2'd0);
        set_fabric(32'd0, 32'd0, 32'd0);
        fab_if.fabric_valid_i = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_start", 32'(fab_if.fabric_start_o), 32'd0);
        chk("rst_res_a", result_a_o, 32'd0);
        chk("rst_delay", 32'(delay_o), 32'd0);
        chk("rst_error", 32'(error_o), 32'd0);
        chk("rst_op_a", fab_if.fabric_op_a_o, 32'd0);
        rst_n = 1'b1;
        tick();

        // Fixed mode, D=3
        set_req(4'd3, 32'd5, 32'd7, 2'd2);
        set_fabric(32'd12, 32'd35, 32'd2);
        write_strobe_i = 1'b1;
        tick();
        write_strobe_i = 1'b0;
        chk("fx_start", 32'(fab_if.fabric_start_o), 32'd1);
        chk("fx_op_a", fab_if.fabric_op_a_o, 32'd5);
        chk("fx_op_b", fab_if.fabric_op_b_o, 32'd7);
        chk("fx_operator", 32'(fab_if.fabric_operator_o), 32'd2);
        chk("fx_delay", 32'(delay_o), 32'd3);
        chk("fx_busy", 32'(busy_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fx_wait_start", 32'(fab_if.fabric_start_o), 32'd0);
            chk("fx_wait_done", 32'(done_o), 32'd0);
            chk("fx_wait_res", result_a_o, 32'd0);
        end
        tick();
        chk("fx_done", 32'(done_o), 32'd1);
        chk("fx_res_a", result_a_o, 32'd12);
        chk("fx_res_b", result_b_o, 32'd35);
        chk("fx_res_c", result_c_o, 32'd2);
        tick();
        chk("fx_done_end", 32'(done_o), 32'd0);
        chk("fx_idle", 32'(busy_o), 32'd0);
        chk("fx_hold", result_a_o, 32'd12);

        // Handshake mode, valid 6 cycles after start
        set_req(4'd0, 32'd1, 32'd2, 2'd1);
        set_fabric(32'd100, 32'd200, 32'd300);
        write_strobe_i = 1'b1;
        tick();
        write_strobe_i = 1'b0;
        chk("hs_start", 32'(fab_if.fabric_start_o), 32'd1);
        chk("hs_delay", 32'(delay_o), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hs_wait_done", 32'(done_o), 32'd0);
            chk("hs_wait_busy", 32'(busy_o), 32'd1);
        end
        fab_if.fabric_valid_i = 1'b1;
        tick();
        fab_if.fabric_valid_i = 1'b0;
        chk("hs_done", 32'(done_o), 32'd1);
        chk("hs_res_a", result_a_o, 32'd100);
        chk("hs_res_c", result_c_o, 32'd300);
        tick();
        chk("hs_done_end", 32'(done_o), 32'd0);
        chk("hs_idle", 32'(busy_o), 32'd0);

        // fabric_valid_i outside WAIT has no effect
        set_fabric(32'd999, 32'd999, 32'd999);
        fab_if.fabric_valid_i = 1'b1;
        tick();
        fab_if.fabric_valid_i = 1'b0;
        chk("idle_valid_res", result_a_o, 32'd100);
        chk("idle_valid_busy", 32'(busy_o), 32'd0);

        // Strobe during LAUNCH/WAIT is ignored
        set_req(4'd2, 32'h11, 32'h12, 2'd0);
        set_fabric(32'h21, 32'h22, 32'h23);
        write_strobe_i = 1'b1;
        tick();
        set_req(4'd5, 32'h99, 32'h98, 2'd3);
        tick();
        chk("ig_op_a_1", fab_if.fabric_op_a_o, 32'h11);
        chk("ig_delay", 32'(delay_o), 32'd2);
        tick();
        write_strobe_i = 1'b0;
        chk("ig_op_a_2", fab_if.fabric_op_a_o, 32'h11);
        chk("ig_no_done", 32'(done_o), 32'd0);
        tick();
        chk("ig_done", 32'(done_o), 32'd1);
        chk("ig_res_a", result_a_o, 32'h21);
        tick();
        chk("ig_single_done", 32'(done_o), 32'd0);
        chk("ig_idle", 32'(busy_o), 32'd0);

        // Back-to-back: strobe in the DONE cycle
        set_req(4'd1, 32'h44, 32'h45, 2'd1);
        set_fabric(32'h55, 32'h56, 32'h57);
        write_strobe_i = 1'b1;
        tick();
        write_strobe_i = 1'b0;
        tick();
        tick();
        chk("b2b_done1", 32'(done_o), 32'd1);
        chk("b2b_res1", result_a_o, 32'h55);
        set_req(4'd1, 32'h66, 32'h67, 2'd2);
        set_fabric(32'h77, 32'h78, 32'h79);
        write_strobe_i = 1'b1;
        tick();
        write_strobe_i = 1'b0;
        chk("b2b_launch", 32'(fab_if.fabric_start_o), 32'd1);
        chk("b2b_busy", 32'(busy_o), 32'd1);
        chk("b2b_op_a", fab_if.fabric_op_a_o, 32'h66);
        chk("b2b_done_off", 32'(done_o), 32'd0);
        tick();
        tick();
        chk("b2b_done2", 32'(done_o), 32'd1);
        chk("b2b_res2", result_a_o, 32'h77);
        tick();

        // Reset in WAIT
        set_req(4'd0, 32'h123, 32'h124, 2'd3);
        write_strobe_i = 1'b1;
        tick();
        write_strobe_i = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mr_res_a", result_a_o, 32'd0);
        chk("mr_op_a", fab_if.fabric_op_a_o, 32'd0);
        chk("mr_delay", 32'(delay_o), 32'd0);
        chk("mr_busy", 32'(busy_o), 32'd0);
        chk("mr_start", 32'(fab_if.fabric_start_o), 32'd0);
        chk("mr_done", 32'(done_o), 32'd0);
        fab_if.fabric_valid_i = 1'b1;
        tick();
        fab_if.fabric_valid_i = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("mr_no_done", 32'(done_o), 32'd0);
        chk("mr_idle", 32'(busy_o), 32'd0);
        set_req(4'd2, 32'h5, 32'h6, 2'd0);
        set_fabric(32'habc, 32'habd, 32'habe);
        write_strobe_i = 1'b1;
        tick();
        write_strobe_i = 1'b0;
        chk("mr_relaunch", 32'(fab_if.fabric_start_o), 32'd1);
        tick();
        tick();
        tick();
        chk("mr_done2", 32'(done_o), 32'd1);
        chk("mr_res2", result_a_o, 32'habc);
        tick();

`ifdef IBEX_EFPGA_TIMEOUT_EN
        // Handshake timeout after 8 WAIT cycles
        set_req(4'd0, 32'h1, 32'h1, 2'd0);
        write_strobe_i = 1'b1;
        tick();
        write_strobe_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("to_wait_done", 32'(done_o), 32'd0);
            chk("to_wait_err", 32'(error_o), 32'd0);
        end
        tick();
        chk("to_done", 32'(done_o), 32'd1);
        chk("to_res_a", result_a_o, 32'hDEADBEEF);
        chk("to_res_b", result_b_o, 32'hDEADBEEF);
        chk("to_err", 32'(error_o), 32'd1);
        tick();
        chk("to_idle", 32'(busy_o), 32'd0);
        set_req(4'd1, 32'h2, 32'h2, 2'd0);
        set_fabric(32'h31, 32'h32, 32'h33);
        write_strobe_i = 1'b1;
        tick();
        write_strobe_i = 1'b0;
        tick();
        tick();
        chk("to_next_done", 32'(done_o), 32'd1);
        chk("to_sticky", 32'(error_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("to_err_clr", 32'(error_o), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
`else
        // Without the timeout the handshake waits indefinitely
        set_req(4'd0, 32'h1, 32'h1, 2'd0);
        set_fabric(32'h41, 32'h42, 32'h43);
        write_strobe_i = 1'b1;
        tick();
        write_strobe_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("nt_wait_done", 32'(done_o), 32'd0);
            chk("nt_wait_busy", 32'(busy_o), 32'd1);
        end
        chk("nt_err", 32'(error_o), 32'd0);
        fab_if.fabric_valid_i = 1'b1;
        tick();
        fab_if.fabric_valid_i = 1'b0;
        chk("nt_done", 32'(done_o), 32'd1);
        chk("nt_res_a", result_a_o, 32'h41);
        chk("nt_err_after", 32'(error_o), 32'd0);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ibex_efpga_responder.md
IBEX_EFPGA_RESPONDER -- requirements
Module: ibex_efpga_responder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum handshake-mode wait in cycles (range 1..255).
REQ-002 SHALL have port clk, input, 1: the single clock.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port write_strobe_i, input, 1: core request strobe.
REQ-005 SHALL have port operator_i, input, 2: eFPGA operator.
REQ-006 SHALL have ports operand_a_i and operand_b_i, input, 32 each: core operands.
REQ-007 SHALL have port cfg_delay_i, input, 4: fixed-latency count; 0 selects handshake mode.
REQ-008 SHALL have ports fabric_op_a_o and fabric_op_b_o (output, 32 each) and fabric_operator_o (output, 2): operands and operator held to the fabric.
REQ-009 SHALL have port fabric_start_o, output, 1: one-cycle launch pulse.
REQ-010 SHALL have ports fabric_result_a_i, fabric_result_b_i and fabric_result_c_i, input, 32 each, plus fabric_valid_i, input, 1.
REQ-011 SHALL have ports result_a_o, result_b_o and result_c_o, output, 32 each: latched results to core.
REQ-012 SHALL have port delay_o, output, 4: cfg_delay_i captured at launch.
REQ-013 SHALL have ports done_o (output, 1, completion pulse to core), busy_o (output, 1, high when state != IDLE) and error_o (output, 1, sticky timeout flag).

Function
REQ-014 SHALL implement FSM states IDLE, LAUNCH, WAIT and DONE.
REQ-015 SHALL, in IDLE or DONE with write_strobe_i=1, capture operands, operator and cfg_delay_i, then enter LAUNCH the next cycle.
REQ-016 SHALL ignore write_strobe_i in LAUNCH and WAIT, with no capture and no state change.
REQ-017 SHALL assert fabric_start_o only in LAUNCH (exactly 1 cycle), load the counter with the captured delay, then enter WAIT.
REQ-018 SHALL, in fixed mode (delay D != 0), decrement the counter each WAIT cycle, sample fabric results when the count reaches 0 (D cycles after LAUNCH), and enter DONE.
REQ-019 SHALL, in handshake mode, sample fabric results in the first WAIT cycle with fabric_valid_i=1 and enter DONE; fabric_valid_i is ignored outside WAIT.
REQ-020 SHALL assert done_o for exactly the one DONE cycle; DONE goes to IDLE, or to LAUNCH on a simultaneous strobe (back-to-back).
REQ-021 SHALL hold result_*_o and delay_o stable until the next sample or capture.
REQ-022 SHALL hold fabric_op_*_o and fabric_operator_o at the captured values from LAUNCH until the next capture.

Reset
REQ-023 SHALL, on rst_n low, immediately set state=IDLE and drive all data outputs to 0 and all flags to 0, including error_o.
REQ-024 SHALL, on reset mid-operation, abandon the operation, produce no done_o, and accept the next strobe normally after release.

Configuration
REQ-025 SHALL, with IBEX_EFPGA_TIMEOUT_EN defined, count handshake-mode WAIT cycles; after TIMEOUT_CYCLES cycles without fabric_valid_i it enters DONE, sets results to 32'hDEADBEEF, and sets error_o (cleared only by reset).
REQ-026 SHALL, without IBEX_EFPGA_TIMEOUT_EN, wait indefinitely in WAIT, tie error_o to 0, and omit the timeout counter logic.

Structure
REQ-027 SHALL place the FSM state enum, the 32'hDEADBEEF constant and the default TIMEOUT_CYCLES value in shared package ibex_efpga_pkg.
REQ-028 SHALL be a single flat module; no sub-module is required.

Verification
REQ-029 SHALL cover fixed mode: cfg_delay=3, strobe with A=5, B=7; fabric results 12/35/2 -> start 1 cycle after strobe, sample 3 cycles after LAUNCH, done_o 1 cycle, result_a_o=12, delay_o=3.
REQ-030 SHALL cover handshake mode: cfg_delay=0, fabric_valid_i asserted 6 cycles after start -> done_o exactly one cycle later, results latched, busy_o low afterward.
REQ-031 SHALL cover strobe during WAIT with different operands -> ignored, fabric_op_a_o unchanged, single done_o.
REQ-032 SHALL cover back-to-back: strobe in DONE cycle -> LAUNCH next cycle, with no IDLE cycle.
REQ-033 SHALL cover rst_n low in WAIT -> outputs 0 immediately, no done_o, and a new strobe after release completes.
REQ-034 SHALL cover, with IBEX_EFPGA_TIMEOUT_EN and TIMEOUT_CYCLES=8, no fabric_valid_i -> done_o after 8 WAIT cycles, results 32'hDEADBEEF, error_o=1 sticky.
